rsa_core_arbiter: RTL and testbench

Shares one RSA-256 exponentiation core (Montgomery datapath with `start`/`finished` handshake) between two independent requesters. Each request carries a 256-bit base, exponent and modulus. The arbiter grants requests round-robin, registers the operands, and issues a single start pulse to the core. It holds the operands stable for the whole computation, captures the result on the finish pulse, and returns it tagged with the requester ID. A watchdog aborts jobs that never finish and reports them as errors.

---
 rtl/rsa_core_arbiter.sv | 176 +++++++++++++++++
 tb/tb_rsa_core_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_core_arbiter.sv
// Round-robin arbiter sharing one RSA exponentiation core between two requesters.
// Holds operands for the whole job, returns tagged results, and aborts hung jobs via a watchdog.
`timescale 1ns/1ps
module rsa_core_arbiter #(
    parameter int unsigned WIDTH   = 256,
    parameter int unsigned TIMEOUT = 1048576
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [WIDTH-1:0] i_req0_a,
    input  logic [WIDTH-1:0] i_req0_d,
    input  logic [WIDTH-1:0] i_req0_n,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [WIDTH-1:0] i_req1_a,
    input  logic [WIDTH-1:0] i_req1_d,
    input  logic [WIDTH-1:0] i_req1_n,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic             o_rsp_id,
    output logic [WIDTH-1:0] o_rsp_data,
    output logic             o_rsp_err,
    output logic             o_core_start,
    output logic [WIDTH-1:0] o_core_a,
    output logic [WIDTH-1:0] o_core_d,
    output logic [WIDTH-1:0] o_core_n,
    input  logic [WIDTH-1:0] i_core_result,
    input  logic             i_core_finished,
    output logic             o_busy
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             last_id_q, last_id_d;
    logic             cur_id_q, cur_id_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;

    logic grant_valid_c;
    logic grant_id_c;
    logic handshake_c;
    logic timeout_c;

    // Round-robin pick: on a tie the requester that was not served last wins.
    always_comb begin
        grant_valid_c = i_req0_valid | i_req1_valid;
        grant_id_c    = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            grant_id_c = ~last_id_q;
        end else if (i_req1_valid) begin
            grant_id_c = 1'b1;
        end
        handshake_c = (state_q == S_IDLE) && grant_valid_c;
        timeout_c   = (cnt_q == CNT_LAST);
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_valid_c) state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT:  if (i_core_finished || timeout_c) state_d = S_RESP;
            S_RESP:  if (i_rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        o_core_start = 1'b0;
        o_rsp_valid  = 1'b0;
        o_busy       = 1'b1;
        case (state_q)
            S_IDLE: begin
                o_busy       = 1'b0;
                o_req0_ready = grant_valid_c && !grant_id_c;
                o_req1_ready = grant_valid_c && grant_id_c;
            end
            S_START: o_core_start = 1'b1;
            S_RESP:  o_rsp_valid  = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values: operands only move on a handshake, result only at the end of WAIT.
    always_comb begin
        last_id_d  = last_id_q;
        cur_id_d   = cur_id_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        d_d        = d_q;
        n_d        = n_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (handshake_c) begin
                    cur_id_d = grant_id_c;
                    a_d      = grant_id_c ? i_req1_a : i_req0_a;
                    d_d      = grant_id_c ? i_req1_d : i_req0_d;
                    n_d      = grant_id_c ? i_req1_n : i_req0_n;
                end
            end
            S_START: cnt_d = '0;
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (i_core_finished) begin
                    rsp_data_d = i_core_result;
                    rsp_err_d  = 1'b0;
                end else if (timeout_c) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                end
            end
            S_RESP: if (i_rsp_ready) last_id_d = cur_id_q;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            last_id_q  <= 1'b1;
            cur_id_q   <= 1'b0;
            cnt_q      <= '0;
            a_q        <= '0;
            d_q        <= '0;
            n_q        <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            last_id_q  <= last_id_d;
            cur_id_q   <= cur_id_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            d_q        <= d_d;
            n_q        <= n_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign o_core_a   = a_q;
    assign o_core_d   = d_q;
    assign o_core_n   = n_q;
    assign o_rsp_id   = cur_id_q;
    assign o_rsp_data = rsp_data_q;
    assign o_rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_rsa_core_arbiter.sv
// Scoreboard bench for rsa_core_arbiter with a behavioural modexp core model.
`timescale 1ns/1ps
module tb_rsa_core_arbiter;

    localparam int unsigned W  = 256;
    localparam int unsigned TO = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0] req0_a = '0, req0_d = '0, req0_n = '0;
    logic [W-1:0] req1_a = '0, req1_d = '0, req1_n = '0;
    logic         rsp_ready = 1'b1;
    logic         req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, core_start, busy;
    logic [W-1:0] rsp_data, core_a, core_d, core_n, core_result;
    logic         core_finished;

    // core model controls
    logic         core_hang = 1'b0, spur_fin = 1'b0, use_man = 1'b0, core_pulse = 1'b0, core_run = 1'b0;
    logic [W-1:0] man_res = '0, core_res = '0, sa = '0, sd = '0, sn = '0;
    int           core_lat = 6, core_cnt = 0;

    typedef struct packed {
        logic         id;
        logic [W-1:0] data;
        logic         err;
    } rsp_t;

    rsp_t exp_q[$];
    logic gnt_q[$];
    int   checks = 0, failures = 0;
    int   n_start = 0, n_rdy0 = 0, n_rdy1 = 0;
    logic start_due = 1'b0;

    always #5 clk = ~clk;

    assign core_finished = core_pulse | spur_fin;
    assign core_result   = use_man ? man_res : core_res;

    rsa_core_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
        .i_req0_a(req0_a), .i_req0_d(req0_d), .i_req0_n(req0_n),
        .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
        .i_req1_a(req1_a), .i_req1_d(req1_d), .i_req1_n(req1_n),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_id(rsp_id), .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
        .o_core_start(core_start), .o_core_a(core_a), .o_core_d(core_d), .o_core_n(core_n),
        .i_core_result(core_result), .i_core_finished(core_finished), .o_busy(busy)
    );

    function automatic logic [W-1:0] modexp(input logic [W-1:0] a, input logic [W-1:0] d,
                                            input logic [W-1:0] n);
        logic [2*W-1:0] r, b, nn;
        nn = (2*W)'(n);
        r  = (2*W)'(1) % nn;
        b  = (2*W)'(a) % nn;
        for (int i = 0; i < int'(W); i++) begin
            if (d[i]) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return r[W-1:0];
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural core: result appears core_lat cycles after start, computed from the live operands.
    always @(posedge clk) begin
        core_pulse <= 1'b0;
        if (core_start) begin
            core_run <= 1'b1;
            core_cnt <= core_lat;
            sa <= core_a; sd <= core_d; sn <= core_n;
        end else if (core_run) begin
            if (core_cnt <= 1) begin
                core_run <= 1'b0;
                if (!core_hang) begin
                    core_pulse <= 1'b1;
                    core_res   <= modexp(core_a, core_d, core_n);
                end
                if (busy) chk("core_ops_stable", W'({core_a == sa, core_d == sd, core_n == sn}), W'(3'b111));
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    // Monitor: grant order, start latency, response scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            start_due <= 1'b0;
        end else begin
            chk("one_ready_max", W'(req0_ready & req1_ready), W'(0));
            if (start_due) chk("start_latency", W'(core_start), W'(1));
            start_due <= 1'b0;
            if (core_start) n_start++;
            if (req0_ready) n_rdy0++;
            if (req1_ready) n_rdy1++;
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                start_due <= 1'b1;
                if (gnt_q.size() == 0) begin
                    chk("unexpected_grant", W'(req1_ready), W'(2));
                end else begin
                    chk("grant_id", W'(req1_ready), W'(gnt_q.pop_front()));
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", W'(rsp_id), W'(2));
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_id", W'(rsp_id), W'(e.id));
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_err", W'(rsp_err), W'(e.err));
                end
            end
        end
    end

    task automatic push_exp(input logic id, input logic [W-1:0] data, input logic err);
        rsp_t e;
        e.id = id; e.data = data; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input logic id, input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] d, input logic [W-1:0] n);
        if (id) begin
            req1_valid = v; req1_a = a; req1_d = d; req1_n = n;
        end else begin
            req0_valid = v; req0_a = a; req0_d = d; req0_n = n;
        end
    endtask

    task automatic wait_hs(input int k);
        int cnt = 0;
        for (int i = 0; i < 400 && cnt < k; i++) begin
            @(negedge clk);
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) cnt++;
        end
        if (cnt < k) chk("wait_handshake", W'(cnt), W'(k));
    endtask

    task automatic wait_start();
        logic seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = core_start;
        end
        if (!seen) chk("wait_start", W'(0), W'(1));
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) chk("rsp_timeout", W'(exp_q.size()), W'(0));
    endtask

    task automatic run_job(input logic id, input logic [W-1:0] a, input logic [W-1:0] d,
                           input logic [W-1:0] n, input logic [W-1:0] res);
        push_exp(id, res, 1'b0);
        gnt_q.push_back(id);
        @(posedge clk); #1;
        set_req(id, 1'b1, a, d, n);
        wait_hs(1);
        @(posedge clk); #1;
        set_req(id, 1'b0, a, d, n);
        wait_empty();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, W'({req0_ready, req1_ready}), W'(0));
        chk({tag, "_rsp_valid"}, W'(rsp_valid), W'(0));
        chk({tag, "_rsp_id_err"}, W'({rsp_id, rsp_err}), W'(0));
        chk({tag, "_rsp_data"}, rsp_data, W'(0));
        chk({tag, "_start_busy"}, W'({core_start, busy}), W'(0));
        chk({tag, "_core_a"}, core_a, W'(0));
        chk({tag, "_core_d"}, core_d, W'(0));
        chk({tag, "_core_n"}, core_n, W'(0));
    endtask

    initial begin
        int s0, r0, lat;

        #12;
        check_all_zero("reset");
        @(negedge clk); rst = 1'b1;

        // single job on req0
        s0 = n_start; r0 = n_rdy0;
        run_job(1'b0, W'(4), W'(13), W'(497), W'(445));
        chk("single_start_pulses", W'(n_start - s0), W'(1));
        chk("single_ready0_cycles", W'(n_rdy0 - r0), W'(1));

        // simultaneous requests after reset (last_id=0 now, so req1 wins first)
        // re-establish the reset tie-break first by serving req1
        run_job(1'b1, W'(3), W'(5), W'(11), W'(1));
        gnt_q.push_back(1'b0); gnt_q.push_back(1'b1);
        push_exp(1'b0, W'(445), 1'b0); push_exp(1'b1, W'(1), 1'b0);
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, W'(4), W'(13), W'(497));
        set_req(1'b1, 1'b1, W'(3), W'(5), W'(11));
        wait_hs(1);
        @(posedge clk); #1; req0_valid = 1'b0;
        wait_hs(1);
        @(posedge clk); #1; req1_valid = 1'b0;
        wait_empty();

        // fairness: both held valid for six jobs
        for (int i = 0; i < 6; i++) begin
            gnt_q.push_back(1'(i % 2));
            push_exp(1'(i % 2), (i % 2) ? W'(1) : W'(445), 1'b0);
        end
        @(posedge clk); #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_hs(6);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_empty();

        // backpressure with a spurious finish during RESP, req1 waiting
        rsp_ready = 1'b0;
        gnt_q.push_back(1'b0);
        push_exp(1'b0, W'(445), 1'b0);
        @(posedge clk); #1;
        req0_valid = 1'b1;
        wait_hs(1);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b1;
        for (int i = 0; i < 100 && !rsp_valid; i++) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            spur_fin = (i == 5); use_man = (i == 5); man_res = W'(16'hDEAD);
            @(negedge clk);
            chk("bp_hold", W'({rsp_valid, rsp_id, rsp_err, req1_ready}), W'(4'b1000));
            chk("bp_data", rsp_data, W'(445));
        end
        spur_fin = 1'b0; use_man = 1'b0;
        gnt_q.push_back(1'b1);
        push_exp(1'b1, W'(1), 1'b0);
        @(posedge clk); #1; rsp_ready = 1'b1;
        wait_hs(1);
        @(posedge clk); #1; req1_valid = 1'b0;
        wait_empty();

        // watchdog: core never finishes
        core_hang = 1'b1;
        gnt_q.push_back(1'b0);
        push_exp(1'b0, W'(0), 1'b1);
        @(posedge clk); #1; req0_valid = 1'b1;
        wait_hs(1);
        @(posedge clk); #1; req0_valid = 1'b0;
        wait_start();
        lat = 0;
        for (int i = 0; i < 100 && !rsp_valid; i++) begin
            @(negedge clk); lat++;
        end
        chk("timeout_latency", W'(lat), W'(TO + 1));
        wait_empty();

        // finish exactly on the last watchdog cycle wins over timeout
        use_man = 1'b1; man_res = W'(32'h1234_5678);
        gnt_q.push_back(1'b1);
        push_exp(1'b1, W'(32'h1234_5678), 1'b0);
        @(posedge clk); #1; req1_valid = 1'b1;
        wait_hs(1);
        @(posedge clk); #1; req1_valid = 1'b0;
        wait_start();
        repeat (TO) @(posedge clk);
        #1; spur_fin = 1'b1;
        @(posedge clk); #1; spur_fin = 1'b0;
        wait_empty();
        core_hang = 1'b0; use_man = 1'b0;

        // async reset in WAIT, after a req0 job so last_id would otherwise be 0
        run_job(1'b0, W'(4), W'(13), W'(497), W'(445));
        gnt_q.push_back(1'b0);
        @(posedge clk); #1; req0_valid = 1'b1;
        wait_hs(1);
        @(posedge clk); #1; req0_valid = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk); rst = 1'b1;
        gnt_q.push_back(1'b0); gnt_q.push_back(1'b1);
        push_exp(1'b0, W'(445), 1'b0); push_exp(1'b1, W'(1), 1'b0);
        @(posedge clk); #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_hs(1);
        @(posedge clk); #1; req0_valid = 1'b0;
        wait_hs(1);
        @(posedge clk); #1; req1_valid = 1'b0;
        wait_empty();
        run_job(1'b1, W'(3), W'(5), W'(11), W'(1));

        repeat (5) @(negedge clk);
        chk("leftover_grants", W'(gnt_q.size()), W'(0));
        chk("leftover_rsps", W'(exp_q.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
